// File: rtl/diy_mole_recorder.sv
// diy_mole_recorder
//   Write side of the DIY mole-timing path. While DIY record mode is active,
//   every clean single-pad stomp is stored as one table entry holding the
//   current music sample address and the mole location of that pad. The
//   playback-side mole timer reads entries back by index.
//
//   Optional build macro: RECORD_UNDO_EN
//     When defined, adds an 'undo' input. Each rising edge removes the most
//     recent entry and restores the spacing reference to the entry before it.
//
// Ports
//   clk            in   system clock (27 MHz)
//   reset          in   synchronous, active-high reset
//   record_en      in   DIY record mode level from the game FSM
//   music_address  in   current music playback address
//   pads           in   debounced pad levels {ul,u,ur,l,r,dl,d,dr}
//   rd_index       in   playback read index
//   undo           in   (RECORD_UNDO_EN only) debounced undo level
//   rd_data        out  registered {address, location}, all ones if invalid
//   total_moles    out  number of valid entries
//   recording      out  high while waiting for stomps
//   full           out  table holds MAX_ITEM entries
//   write_pulse    out  one-cycle pulse per stored entry
module diy_mole_recorder #(
  parameter int                    MAX_ITEM   = 128,
  parameter int                    INDEX_BITS = 7,
  parameter int                    ADDR_BITS  = 23,
  parameter logic [ADDR_BITS-1:0]  MIN_GAP    = 23'h3000
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    record_en,
  input  logic [ADDR_BITS-1:0]    music_address,
  input  logic [7:0]              pads,
  input  logic [INDEX_BITS-1:0]   rd_index,
`ifdef RECORD_UNDO_EN
  input  logic                    undo,
`endif
  output logic [ADDR_BITS+2:0]    rd_data,
  output logic [INDEX_BITS:0]     total_moles,
  output logic                    recording,
  output logic                    full,
  output logic                    write_pulse
);

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_ARM       = 3'd1;
  localparam logic [2:0] S_RECORDING = 3'd2;
  localparam logic [2:0] S_WRITE     = 3'd3;
  localparam logic [2:0] S_DONE      = 3'd4;
`ifdef RECORD_UNDO_EN
  localparam logic [2:0] S_UNDO      = 3'd5;
`endif

  logic [2:0]             r_state;
  logic                   r_recordEnPrev;
  logic [7:0]             r_padsPrev;
  logic [INDEX_BITS:0]    r_total;
  logic [ADDR_BITS-1:0]   r_lastAddr;
  logic [ADDR_BITS-1:0]   r_pendAddr;
  logic [2:0]             r_pendLoc;
  logic [ADDR_BITS+2:0]   r_rdData;
  logic [ADDR_BITS+2:0]   r_table [MAX_ITEM];

  logic                   w_recordRise;
  logic                   w_oneHot;
  logic                   w_press;
  logic [2:0]             w_loc;
  logic [ADDR_BITS-1:0]   w_gap;
  logic                   w_full;
  logic                   w_accept;

`ifdef RECORD_UNDO_EN
  logic                   r_undoPrev;
  logic                   r_undoPend;
  logic                   w_undoReq;
  logic [INDEX_BITS:0]    w_totalMinus2;
  logic [INDEX_BITS-1:0]  w_undoIdx;

  // An undo edge seen during WRITE is remembered and served in RECORDING.
  assign w_undoReq     = (undo && !r_undoPrev) || r_undoPend;
  assign w_totalMinus2 = r_total - (INDEX_BITS+1)'(2);
  assign w_undoIdx     = w_totalMinus2[INDEX_BITS-1:0];
`endif

  assign w_recordRise = record_en && !r_recordEnPrev;
  assign w_oneHot     = (pads != 8'd0) && ((pads & (pads - 8'd1)) == 8'd0);
  // A press must start from all pads released, so held or chorded pads never count.
  assign w_press      = (r_padsPrev == 8'd0) && w_oneHot;
  assign w_gap        = music_address - r_lastAddr;
  assign w_full       = (r_total == (INDEX_BITS+1)'(MAX_ITEM));
  // The first entry needs no spacing; later ones must move forward by at least MIN_GAP.
  assign w_accept     = !w_full &&
                        ((r_total == '0) ||
                         ((music_address > r_lastAddr) && (w_gap >= MIN_GAP)));

  // Pad bit 7 maps to location 0 down to bit 0 mapping to location 7.
  always_comb begin
    w_loc = 3'd0;
    for (int i = 0; i < 8; i++) begin
      if (pads[i]) w_loc = 3'(7 - i);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state        <= S_IDLE;
      r_total        <= '0;
      r_lastAddr     <= '0;
      r_recordEnPrev <= 1'b0;
      r_padsPrev     <= 8'd0;
      r_pendAddr     <= '0;
      r_pendLoc      <= 3'd0;
`ifdef RECORD_UNDO_EN
      r_undoPrev     <= 1'b0;
      r_undoPend     <= 1'b0;
`endif
    end else begin
      r_recordEnPrev <= record_en;
      r_padsPrev     <= pads;
`ifdef RECORD_UNDO_EN
      r_undoPrev     <= undo;
      if (r_state == S_WRITE) begin
        if (undo && !r_undoPrev) r_undoPend <= 1'b1;
      end else begin
        r_undoPend <= 1'b0;
      end
`endif
      case (r_state)
        S_IDLE, S_DONE: begin
          if (w_recordRise) r_state <= S_ARM;
        end
        S_ARM: begin
          r_total <= '0;
          if (!record_en)          r_state <= S_DONE;
          else if (pads == 8'd0)   r_state <= S_RECORDING;
        end
        S_RECORDING: begin
          // Leaving record mode beats a simultaneous press.
          if (!record_en) begin
            r_state <= S_DONE;
`ifdef RECORD_UNDO_EN
          end else if (w_undoReq && (r_total != '0)) begin
            r_state <= S_UNDO;
`endif
          end else if (w_press && w_accept) begin
            r_state    <= S_WRITE;
            r_pendAddr <= music_address;
            r_pendLoc  <= w_loc;
          end
        end
        S_WRITE: begin
          r_total    <= r_total + 1'b1;
          r_lastAddr <= r_pendAddr;
          r_state    <= record_en ? S_RECORDING : S_DONE;
        end
`ifdef RECORD_UNDO_EN
        S_UNDO: begin
          r_total    <= r_total - 1'b1;
          r_lastAddr <= (r_total == (INDEX_BITS+1)'(1)) ? '0
                        : r_table[w_undoIdx][ADDR_BITS+2:3];
          r_state    <= record_en ? S_RECORDING : S_DONE;
        end
`endif
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Table storage is never cleared; a write in a reset cycle is dropped.
  always_ff @(posedge clk) begin
    if (!reset && (r_state == S_WRITE)) begin
      r_table[r_total[INDEX_BITS-1:0]] <= {r_pendAddr, r_pendLoc};
    end
  end

  // Indices at or past the current count read as all ones, using the count
  // before any write landing on this same edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_rdData <= '1;
    end else if ({1'b0, rd_index} >= r_total) begin
      r_rdData <= '1;
    end else begin
      r_rdData <= r_table[rd_index];
    end
  end

  assign rd_data     = r_rdData;
  assign total_moles = r_total;
  assign recording   = (r_state == S_RECORDING);
  assign full        = w_full;
  assign write_pulse = (r_state == S_WRITE);

endmodule

// File: tb/tb_diy_mole_recorder.sv
// tb_diy_mole_recorder
//   Self-checking bench for diy_mole_recorder. Keeps a queue of expected
//   table entries plus the expected count and spacing reference, and checks
//   write pulses, counts, status flags and read-back data against it.
//   Undo steps are built only when RECORD_UNDO_EN is defined.
module tb_diy_mole_recorder;

  logic        clk;
  logic        reset;
  logic        record_en;
  logic [22:0] music_address;
  logic [7:0]  pads;
  logic [6:0]  rd_index;
`ifdef RECORD_UNDO_EN
  logic        undo;
`endif
  logic [25:0] rd_data;
  logic [7:0]  total_moles;
  logic        recording;
  logic        full;
  logic        write_pulse;

  int          checks = 0;
  int          errors = 0;

  int          mTotal;
  int          mLast;
  logic [25:0] mTab[$];

  diy_mole_recorder dut (
    .clk           (clk),
    .reset         (reset),
    .record_en     (record_en),
    .music_address (music_address),
    .pads          (pads),
    .rd_index      (rd_index),
`ifdef RECORD_UNDO_EN
    .undo          (undo),
`endif
    .rd_data       (rd_data),
    .total_moles   (total_moles),
    .recording     (recording),
    .full          (full),
    .write_pulse   (write_pulse)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
      else begin
        errors++;
        $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
  endtask

  function automatic bit modelAccept(input int addr, input logic [7:0] p);
    if ($countones(p) != 1) return 1'b0;
    if (mTotal >= 128) return 1'b0;
    if (mTotal == 0) return 1'b1;
    return (addr > mLast) && ((addr - mLast) >= 'h3000);
  endfunction

  function automatic logic [2:0] modelLoc(input logic [7:0] p);
    logic [2:0] loc;
    loc = 3'd0;
    for (int b = 7; b >= 0; b--) if (p[b]) loc = 3'(7 - b);
    return loc;
  endfunction

  // One press cycle followed by a release cycle; the model is updated on accept.
  task automatic applyStimulus(input int addr, input logic [7:0] p, input string tag);
    bit exp;
    logic [22:0] a;
    exp = modelAccept(addr, p);
    a = addr[22:0];
    music_address = a;
    pads = p;
    tick();
    checkOutput({tag, "_pulse"}, {31'd0, write_pulse}, {31'd0, exp});
    pads = 8'd0;
    tick();
    if (exp) begin
      mTab.push_back({a, modelLoc(p)});
      mTotal++;
      mLast = addr;
    end
    checkOutput({tag, "_total"}, {24'd0, total_moles}, mTotal);
  endtask

  task automatic readCheck(input int idx, input string tag);
    logic [25:0] exp;
    rd_index = idx[6:0];
    tick();
    exp = (idx < mTotal) ? mTab[idx] : 26'h3FFFFFF;
    checkOutput(tag, {6'd0, rd_data}, {6'd0, exp});
  endtask

  initial begin
    int cur;
    int step;
    int r;
    logic [7:0] p;

    reset = 1'b1;
    record_en = 1'b0;
    music_address = '0;
    pads = 8'd0;
    rd_index = '0;
`ifdef RECORD_UNDO_EN
    undo = 1'b0;
`endif
    mTotal = 0;
    mLast = 0;
    tick();
    tick();
    checkOutput("rst_total", {24'd0, total_moles}, 32'd0);
    checkOutput("rst_recording", {31'd0, recording}, 32'd0);
    checkOutput("rst_full", {31'd0, full}, 32'd0);
    checkOutput("rst_pulse", {31'd0, write_pulse}, 32'd0);
    checkOutput("rst_rd", {6'd0, rd_data}, 32'h3FFFFFF);
    reset = 1'b0;
    tick();

    record_en = 1'b1;
    tick();
    tick();
    checkOutput("arm_recording", {31'd0, recording}, 32'd1);

    applyStimulus('h1000, 8'h40, "first");
    readCheck(0, "first_rd");

    applyStimulus('h3FFF, 8'h04, "gap_short");
    applyStimulus('h4000, 8'h04, "gap_exact");
    readCheck(1, "gap_rd");

    applyStimulus('h9000, 8'h41, "chord");
    applyStimulus('h2000, 8'h08, "backwards");

    for (int it = 0; it < 1000 && mTotal < 128; it++) begin
      step = $urandom_range('h4800, 'h2000);
      cur = mLast + step;
      if (($urandom_range(7, 0) == 0) && (mLast > 'h100)) cur = mLast - 'h100;
      r = $urandom_range(7, 0);
      if (r < 6) p = 8'h01 << $urandom_range(7, 0);
      else       p = 8'($urandom);
      applyStimulus(cur, p, "rand");
    end
    checkOutput("fill_total", {24'd0, total_moles}, 32'd128);
    checkOutput("fill_full", {31'd0, full}, 32'd1);
    applyStimulus(mLast + 'h10000, 8'h02, "over_full");
    checkOutput("full_recording", {31'd0, recording}, 32'd1);
    readCheck(127, "last_rd");
    for (int k = 0; k < 6; k++) readCheck($urandom_range(127, 0), "rand_rd");

    record_en = 1'b0;
    music_address = 23'(mLast + 'h10000);
    pads = 8'h10;
    tick();
    checkOutput("drop_pulse", {31'd0, write_pulse}, 32'd0);
    checkOutput("drop_recording", {31'd0, recording}, 32'd0);
    pads = 8'd0;
    tick();
    checkOutput("done_total", {24'd0, total_moles}, 32'd128);
    record_en = 1'b1;
    tick();
    tick();
    mTotal = 0;
    mTab.delete();
    checkOutput("rearm_total", {24'd0, total_moles}, 32'd0);
    checkOutput("rearm_full", {31'd0, full}, 32'd0);
    checkOutput("rearm_recording", {31'd0, recording}, 32'd1);
    readCheck(0, "rearm_rd");

    music_address = 23'h5000;
    pads = 8'h80;
    rd_index = 7'd0;
    tick();
    checkOutput("same_pulse", {31'd0, write_pulse}, 32'd1);
    pads = 8'd0;
    tick();
    checkOutput("same_rd", {6'd0, rd_data}, 32'h3FFFFFF);
    checkOutput("same_total", {24'd0, total_moles}, 32'd1);
    mTab.push_back({23'h5000, 3'd0});
    mTotal = 1;
    mLast = 'h5000;
    readCheck(0, "same_next_rd");

`ifdef RECORD_UNDO_EN
    applyStimulus('h9000, 8'h02, "undo_e1");
    applyStimulus('hD000, 8'h01, "undo_e2");
    undo = 1'b1;
    tick();
    tick();
    undo = 1'b0;
    tick();
    void'(mTab.pop_back());
    mTotal = 2;
    mLast = 'h9000;
    checkOutput("undo_total", {24'd0, total_moles}, 32'd2);
    applyStimulus('hC000, 8'h20, "undo_redo");
    readCheck(2, "undo_rd");
`endif

    reset = 1'b1;
    tick();
    checkOutput("midrst_total", {24'd0, total_moles}, 32'd0);
    checkOutput("midrst_recording", {31'd0, recording}, 32'd0);
    checkOutput("midrst_rd", {6'd0, rd_data}, 32'h3FFFFFF);
    reset = 1'b0;
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
